// File: rtl/convb_param_loader.sv
// ConvB parameter loader: streams weights then biases into per-unit memories.
// Optional running checksum of accepted words: CONVB_LOADER_CHECKSUM_EN.
module convb_param_loader #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 15,
  parameter int IFM_DEPTH         = 3,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 6,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int WPF               = KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      riscv_data,
  output logic [ADDRESS_BITS-1:0]    riscv_address,
  output logic [NUMBER_OF_UNITS-1:0] wm_enable_write,
  output logic [NUMBER_OF_UNITS-1:0] bm_enable_write,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      checksum
);

  localparam int WW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int UW = (NUMBER_OF_UNITS > 1) ?
                      $clog2(NUMBER_OF_UNITS) : 1;
  localparam int FW = (NUMBER_OF_FILTERS > 1) ?
                      $clog2(NUMBER_OF_FILTERS) + 1 : 1;

  localparam logic [WW-1:0] W_LAST = WW'(WPF - 1);
  localparam logic [UW-1:0] U_LAST = UW'(NUMBER_OF_UNITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(NUMBER_OF_FILTERS - 1);
  localparam logic [ADDRESS_BITS-1:0] WPF_A = ADDRESS_BITS'(WPF);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0]           w_q;
  logic [UW-1:0]           u_q;
  logic [FW-1:0]           s_q;
  logic [FW-1:0]           f_q;
  logic [ADDRESS_BITS-1:0] base_q;

  logic go, acc, acc_w, acc_b;
  logic w_wrap, u_wrap, f_last;
  logic [NUMBER_OF_UNITS-1:0] unit_oh;

  assign in_ready = (state_q == LOAD_W) | (state_q == LOAD_B);
  assign busy     = (state_q != IDLE);
  assign go       = (state_q == IDLE) & start & ~abort;
  assign acc      = in_valid & in_ready & ~abort;
  assign acc_w    = acc & (state_q == LOAD_W);
  assign acc_b    = acc & (state_q == LOAD_B);
  assign w_wrap   = (w_q == W_LAST);
  assign u_wrap   = (u_q == U_LAST);
  assign f_last   = (f_q == F_LAST);
  assign unit_oh  = NUMBER_OF_UNITS'(1) << u_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = LOAD_W;
        LOAD_W:  if (acc_w & w_wrap & f_last) state_d = LOAD_B;
        LOAD_B:  if (acc_b & f_last) state_d = FLUSH;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // f_q tracks the global filter index so no division is needed for the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q    <= '0;
      u_q    <= '0;
      s_q    <= '0;
      f_q    <= '0;
      base_q <= '0;
    end else begin
      unique case (1'b1)
        go, (acc_w & w_wrap & f_last): begin
          w_q    <= '0;
          u_q    <= '0;
          s_q    <= '0;
          f_q    <= '0;
          base_q <= '0;
        end
        (acc_w & ~w_wrap): begin
          w_q <= w_q + 1'b1;
        end
        (acc_w & w_wrap & ~f_last), acc_b: begin
          w_q <= '0;
          f_q <= f_q + 1'b1;
          if (u_wrap) begin
            u_q    <= '0;
            s_q    <= s_q + 1'b1;
            base_q <= base_q + WPF_A;
          end else begin
            u_q <= u_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      riscv_data      <= '0;
      riscv_address   <= '0;
      wm_enable_write <= '0;
      bm_enable_write <= '0;
      done            <= 1'b0;
    end else begin
      wm_enable_write <= '0;
      bm_enable_write <= '0;
      done            <= (state_q == FLUSH) & ~abort;
      if (acc) begin
        riscv_data      <= in_data;
        riscv_address   <= acc_w ? base_q + ADDRESS_BITS'(w_q)
                                 : ADDRESS_BITS'(s_q);
        wm_enable_write <= acc_w ? unit_oh : '0;
        bm_enable_write <= acc_b ? unit_oh : '0;
      end
    end
  end

`ifdef CONVB_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (go) begin
      sum_q <= '0;
    end else if (acc) begin
      sum_q <= sum_q + in_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_convb_param_loader.sv
// Self-checking bench for convb_param_loader.
// Routing table plus a stream-level reference model.
module tb_convb_param_loader;

  localparam int DW  = 32;
  localparam int AB  = 15;
  localparam int NF  = 6;
  localparam int NU  = 3;
  localparam int WPF = 75;
  localparam int TOT = NF * (WPF + 1);
`ifdef CONVB_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] riscv_data;
  logic [AB-1:0] riscv_address;
  logic [NU-1:0] wm;
  logic [NU-1:0] bm;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  convb_param_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .riscv_data      (riscv_data),
    .riscv_address   (riscv_address),
    .wm_enable_write (wm),
    .bm_enable_write (bm),
    .busy            (busy),
    .done            (done),
    .checksum        (checksum)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: k-th accepted word of a load -> address and strobes.
  function automatic void mdl(input int k, output int addr,
                              output int ewm, output int ebm);
    int f, b;
    if (k < NF * WPF) begin
      f    = k / WPF;
      addr = (f / NU) * WPF + (k % WPF);
      ewm  = 1 << (f % NU);
      ebm  = 0;
    end else begin
      b    = k - NF * WPF;
      addr = b / NU;
      ewm  = 0;
      ebm  = 1 << (b % NU);
    end
  endfunction

  int            mdl_idx = 0;
  logic [DW-1:0] mdl_sum = '0;
  bit            pa = 0;
  bit            fin = 0;
  bit            fin_now;
  int            pidx;
  logic [DW-1:0] pdata;
  int            n_strb = 0;
  int            n_wm = 0;
  int            n_bm = 0;
  int            n_done = 0;
  bit            cap_en = 0;
  logic [52:0]   cap [TOT];
  int            m_ea, m_ewm, m_ebm;

  always @(negedge clk) begin
    if (!reset) begin
      pa  = 0;
      fin = 0;
    end else begin
      fin_now = 0;
      if (pa) begin
        mdl(pidx, m_ea, m_ewm, m_ebm);
        chk($sformatf("strobe_%0d", pidx),
            {riscv_address, riscv_data, wm, bm},
            {AB'(m_ea), pdata, 3'(m_ewm), 3'(m_ebm)});
        n_strb++;
        if (wm != 0) n_wm++;
        if (bm != 0) n_bm++;
        if (cap_en) cap[pidx] = {riscv_address, riscv_data, wm, bm};
        fin_now = (pidx == TOT - 1);
      end else begin
        chk("no_strobe", {wm, bm}, 64'd0);
      end
      chk("done", done, fin);
      if (done) begin
        n_done++;
        chk("checksum_at_done", checksum, CK_EN ? mdl_sum : '0);
      end
      pa = in_valid && in_ready && !abort;
      if (pa) begin
        pidx  = mdl_idx;
        pdata = in_data;
        mdl_idx++;
        mdl_sum = mdl_sum + in_data;
      end
      fin = fin_now;
    end
  end

  typedef struct {
    int          k;
    logic [31:0] data;
    int          addr;
    logic [2:0]  ewm;
    logic [2:0]  ebm;
  } vec_t;

  vec_t tbl [10];

  task automatic do_start();
    @(posedge clk); #1;
    mdl_idx = 0;
    mdl_sum = '0;
    start   = 1'b1;
    @(negedge clk);
    chk("busy_before_start", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {busy, in_ready}, 2'b11);
  endtask

  // mode 0: valid held high, 1: toggling, 2: random valid/data/stray start
  task automatic feed(input int n, input int mode);
    int k = 0;
    int cyc = 0;
    bit tog = 1'b1;
    while (k < n && cyc < 4 * n + 20) begin
      @(posedge clk); #1;
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = tog;
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      tog     = ~tog;
      in_data = (mode == 2) ? $urandom : DW'(k + 1);
      start   = (mode == 2) && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    chk($sformatf("feed_count_m%0d", mode), k, n);
    if (mode == 0) chk("feed_no_bubbles", cyc, n);
  endtask

  task automatic full_load(input int mode, input string nm);
    int d0, w0, b0;
    d0 = n_done;
    w0 = n_wm;
    b0 = n_bm;
    do_start();
    feed(TOT, mode);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_wm_strobes"}, n_wm - w0, NF * WPF);
    chk({nm, "_bm_strobes"}, n_bm - b0, NF);
    chk({nm, "_done_pulses"}, n_done - d0, 1);
    chk({nm, "_idle"}, {busy, in_ready}, 2'b00);
  endtask

  int s0, d0;

  initial begin
    tbl[0] = '{0,   32'd1,   0,   3'b001, 3'b000};
    tbl[1] = '{74,  32'd75,  74,  3'b001, 3'b000};
    tbl[2] = '{75,  32'd76,  0,   3'b010, 3'b000};
    tbl[3] = '{150, 32'd151, 0,   3'b100, 3'b000};
    tbl[4] = '{225, 32'd226, 75,  3'b001, 3'b000};
    tbl[5] = '{310, 32'd311, 85,  3'b010, 3'b000};
    tbl[6] = '{449, 32'd450, 149, 3'b100, 3'b000};
    tbl[7] = '{450, 32'd451, 0,   3'b000, 3'b001};
    tbl[8] = '{453, 32'd454, 1,   3'b000, 3'b001};
    tbl[9] = '{455, 32'd456, 1,   3'b000, 3'b100};

    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {in_ready, riscv_data, riscv_address, wm, bm, busy, done},
        '0);
    chk("reset_checksum", checksum, '0);
    @(negedge clk);
    reset = 1'b1;

    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", {busy, in_ready}, 2'b00);

    cap_en = 1'b1;
    full_load(0, "full");
    cap_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("route_k%0d", tbl[i].k), cap[tbl[i].k],
          {AB'(tbl[i].addr), tbl[i].data, tbl[i].ewm, tbl[i].ebm});
    end
    repeat (3) @(posedge clk);
    #1;
    chk("checksum_hold", checksum, CK_EN ? 32'd104196 : 32'd0);

    full_load(1, "toggle");
    full_load(2, "random");

    do_start();
    feed(100, 0);
    d0    = n_done;
    s0    = n_strb;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ready_low", {busy, in_ready}, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_extra_strobes", (n_strb - s0) <= 1, 1'b1);
    chk("abort_no_done", n_done - d0, 0);
    do_start();
    feed(1, 0);
    @(negedge clk);
    chk("restart_addr0_unit0", {riscv_address, wm, bm},
        {15'd0, 3'b001, 3'b000});
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    do_start();
    feed(200, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs",
        {in_ready, riscv_data, riscv_address, wm, bm, busy, done},
        '0);
    chk("async_reset_checksum", checksum, '0);
    #3;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", {busy, in_ready}, 2'b00);
    end
    full_load(0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
